sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (0 mario, 1 luigi, 2 gomba, 3 coin).
REQ-002 Parameter ROM_LAT, default 2: fixed shared-ROM read latency in Clk cycles, 1..4.
REQ-003 Parameter AW, default 16: ROM address width.
REQ-004 Parameter DW, default 24: ROM pixel width (RGB888).
REQ-005 Clk  input  1  system clock; single clock domain.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 frame_clk  input  1  VGA_VS-derived frame strobe; level sampled on Clk.
REQ-008 req  input  NREQ  per-requester read request; held until granted or withdrawn.
REQ-009 req_addr  input  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
REQ-010 gnt  output  NREQ  one-hot grant, combinational, same cycle as the winning req.
REQ-011 rvalid  output  NREQ  one-hot return strobe, registered.
REQ-012 rdata  output  DW  returned pixel; broadcast to all requesters; qualified by rvalid.
REQ-013 rom_rd  output  1  shared ROM read enable.
REQ-014 rom_addr  output  AW  shared ROM address.
REQ-015 rom_data  input  DW  shared ROM data, valid ROM_LAT cycles after rom_rd.
REQ-016 frame_grants  output  16  grants issued during the previous complete frame.

Function
REQ-017 Arbitration: round-robin; search order is ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ); the first requester with req high wins.
REQ-018 At most one gnt bit per cycle; gnt is all-zero when req is all-zero.
REQ-019 rom_rd = |req; rom_addr = req_addr slice of the winner; rom_addr = 0 when idle.
REQ-020 After a grant to requester w, ptr <= (w+1) mod NREQ; with no grant, ptr holds.
REQ-021 Tag pipeline: ROM_LAT stages of {valid, index}; rvalid[w] is asserted exactly ROM_LAT cycles after gnt[w], with rdata = rom_data in that cycle.
REQ-022 rdata holds its last value when no rvalid bit is set.
REQ-023 Throughput: one grant per cycle with no bubbles; back-to-back grants to the same requester are legal.
REQ-024 Withdrawing req before a grant is legal and has no side effect; req_addr may change while ungranted.
REQ-025 Frame edge: a registered copy of frame_clk detects the rising edge (frame_clk=1, previous=0); the edge cycle is the cycle in which that detection holds.
REQ-026 On the edge cycle, arbitration uses ptr = 0 regardless of the stored ptr; REQ-020 then applies to that cycle's grant.
REQ-027 Grant counter cnt (16 bit) increments on each grant and saturates at 16'hFFFF.
REQ-028 On the edge cycle, frame_grants <= cnt (grants before this cycle), and cnt <= 1 if a grant occurs this cycle, else 0.
REQ-029 In-flight reads are unaffected by frame edges.

Reset
REQ-030 While Reset is high at a Clk edge, the following are cleared: ptr=0, cnt=0, frame_grants=0, frame_clk history=0, all tag stages invalid, rvalid=0, rdata=0.
REQ-031 Mid-operation reset discards in-flight reads; no rvalid is asserted for reads granted before or during reset.
REQ-032 gnt and rom_rd remain combinational during reset; requesters ignore them while Reset is high.

Structure
REQ-033 The shared package sprite_arb_pkg holds NREQ, ROM_LAT, AW and DW defaults, the requester index enum (REQ_MARIO, REQ_LUIGI, REQ_GOMBA, REQ_COIN) and the tag struct {valid, index}.
REQ-034 One combinational sub-module, rr_pick, is instantiated: inputs req and ptr; outputs one-hot gnt and the winner index.
REQ-035 The shared sprite ROM stays outside this block; the top level connects it through rom_rd, rom_addr and rom_data.

Verification
REQ-036 Reset, then req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rvalid follows the same order, each pulse 2 cycles after its gnt.
REQ-037 Only req[2] held for 5 cycles with addr 0x0010..0x0014 -> gnt[2] in every cycle; rdata equals the ROM contents at 0x0010..0x0014 on 5 consecutive rvalid[2] cycles.
REQ-038 ptr=3 and req=4'b1001 at a frame_clk rising edge -> gnt=4'b0001 (not 4'b1000); requester 3 is granted the next cycle.
REQ-039 37 grants in one frame, then frame_clk rises -> frame_grants=37; cnt restarts at 0, or 1 if a grant occurs on the edge cycle.
REQ-040 Grant to requester 1, then Reset asserted 1 cycle later -> no rvalid pulse; ptr=0 after reset.
REQ-041 Force cnt to 16'hFFFE, then issue 3 grants -> cnt saturates at 16'hFFFF; frame_grants=16'hFFFF at the next edge.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared definitions for the sprite ROM arbiter: default sizing, requester
// names and the read-tag format carried alongside each ROM access.
package sprite_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int ROM_LAT_DEF = 2;
  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 24;
  localparam int IDX_W       = $clog2(NREQ_DEF);

  typedef enum logic [IDX_W-1:0] {
    REQ_MARIO = 0,
    REQ_LUIGI = 1,
    REQ_GOMBA = 2,
    REQ_COIN  = 3
  } req_idx_e;

  // One in-flight ROM read: who asked for it and whether the slot is live.
  typedef struct packed {
    logic     valid;
    req_idx_e index;
  } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting at ptr and
// returns a one-hot grant plus the binary index of the first active one.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  // Rotating priority search: first requester at or after ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned; otherwise synthesis would infer a latch.
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (req[j] && (gnt == '0)) begin
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one fixed-latency sprite ROM among several pixel requesters.
// One grant per cycle, round-robin with a per-frame pointer restart, a tag
// pipeline that routes each returning word to its requester, and a per-frame
// grant counter.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               rom_rd,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic [15:0]        frame_grants
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic             frame_prev;
  logic             frame_edge;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_eff;
  logic [IDX_W-1:0] win;
  logic             any_req;
  logic [15:0]      cnt;
  tag_t             tag_q [ROM_LAT];
  tag_t             last_tag;
  logic             ret_valid;
  logic [DW-1:0]    rdata_q;

  assign frame_edge = frame_clk & ~frame_prev;
  assign ptr_eff    = frame_edge ? '0 : ptr;
  assign any_req    = |req;
  assign rom_rd     = any_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr_eff),
    .gnt (gnt),
    .idx (win)
  );

  // Route the winner's address to the ROM; park the bus at zero when idle.
  always_comb begin
    rom_addr = '0;
    if (any_req) rom_addr = req_addr[int'(win)*AW +: AW];
  end

  // Frame-strobe history and round-robin pointer advance.
  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    if (Reset) begin
      frame_prev <= 1'b0;
      ptr        <= '0;
    end else begin
      frame_prev <= frame_clk;
      if (any_req) ptr <= (int'(win) == NREQ-1) ? '0 : win + 1'b1;
    end
  end

  // Saturating grant counter, snapshotted and restarted on each frame edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt          <= '0;
      frame_grants <= '0;
    end else if (frame_edge) begin
      frame_grants <= cnt;
      cnt          <= any_req ? 16'd1 : 16'd0;
    end else if (any_req && (cnt != CNT_MAX)) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Tag pipeline: one stage per cycle of ROM latency, aligned with the data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: each tag stage is cleared explicitly; a stale valid bit left
      // over from before reset would otherwise fire a phantom rvalid.
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: any_req, index: req_idx_e'(win)};
      for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The return strobe is a decode of the last tag register; it is masked
  // while Reset is high so reads caught by a reset never report back.
  assign last_tag  = tag_q[ROM_LAT-1];
  assign ret_valid = last_tag.valid & ~Reset;

  // One-hot return strobe for the requester that owns the arriving word.
  always_comb begin
    rvalid = '0;
    if (ret_valid) rvalid[last_tag.index] = 1'b1;
  end

  // Hold the most recent returned pixel between returns.
  always_ff @(posedge Clk) begin
    if (Reset)          rdata_q <= '0;
    else if (ret_valid) rdata_q <= rom_data;
  end

  assign rdata = ret_valid ? rom_data : rdata_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized self-checking bench for sprite_rom_arbiter with a scoreboard
// model of arbitration, ROM returns and per-frame grant counting.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int ROM_LAT = 2;
  localparam int AW      = 16;
  localparam int DW      = 24;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               frame_clk;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               rom_rd;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [15:0]        frame_grants;

  sprite_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(ROM_LAT), .AW(AW), .DW(DW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .req          (req),
    .req_addr     (req_addr),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rom_rd       (rom_rd),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .frame_grants (frame_grants)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM contents: an arbitrary but address-unique pattern.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8] + 8'h3C, ~a[7:0]};
  endfunction

  // External ROM with ROM_LAT cycles of read latency.
  logic [AW-1:0] a_hist [ROM_LAT];
  always @(posedge Clk) begin
    a_hist[0] <= rom_addr;
    for (int i = 1; i < ROM_LAT; i++) a_hist[i] <= a_hist[i-1];
  end
  assign rom_data = rom_word(a_hist[ROM_LAT-1]);

  // Scoreboard state.
  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          pend [$];
  int            m_ptr, m_cnt, m_fg, cyc;
  bit            m_prev;
  logic [DW-1:0] m_rdata;

  int errors = 0;
  int checks = 0;

  // Values observed in the most recent step, for targeted checks.
  logic [NREQ-1:0] seen_gnt, seen_rvalid;
  logic [DW-1:0]   seen_rdata;
  logic [15:0]     seen_fg, seen_cnt;
  logic [IDX_W-1:0] seen_ptr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NREQ*AW-1:0] rand_addrs();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: drive at the falling edge, compare just after, update
  // the model for the coming rising edge, then move to the next falling edge.
  task automatic step(input bit rst, input logic [NREQ-1:0] r,
                      input logic [NREQ*AW-1:0] a, input bit fclk);
    int              p, win;
    bit              edge_now, ret;
    logic [NREQ-1:0] eg, erv;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ed;
    Reset = rst; req = r; req_addr = a; frame_clk = fclk;
    #2;
    edge_now = fclk && !m_prev;
    p   = edge_now ? 0 : m_ptr;
    win = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && r[(p + k) % NREQ]) win = (p + k) % NREQ;
    eg = '0; ea = '0;
    if (win >= 0) begin
      eg[win] = 1'b1;
      ea      = a[win*AW +: AW];
    end
    ret = !rst && pend.size() > 0 && pend[0].due == cyc;
    erv = '0; ed = m_rdata;
    if (ret) begin
      erv[pend[0].idx] = 1'b1;
      ed = pend[0].data;
    end
    seen_gnt = gnt; seen_rvalid = rvalid; seen_rdata = rdata;
    seen_fg = frame_grants; seen_cnt = dut.cnt; seen_ptr = dut.ptr;
    check("gnt", gnt, eg);
    check("rom_rd", rom_rd, r != '0);
    check("rom_addr", rom_addr, ea);
    check("rvalid", rvalid, erv);
    check("rdata", rdata, ed);
    check("frame_grants", frame_grants, m_fg);
    if (rst) begin
      pend.delete();
      m_ptr = 0; m_cnt = 0; m_fg = 0; m_prev = 0; m_rdata = '0;
    end else begin
      if (ret) begin
        m_rdata = ed;
        void'(pend.pop_front());
      end
      if (win >= 0) begin
        pend.push_back('{cyc + ROM_LAT, win, rom_word(ea)});
        m_ptr = (win + 1) % NREQ;
      end
      if (edge_now) begin
        m_fg  = m_cnt;
        m_cnt = (win >= 0) ? 1 : 0;
      end else if (win >= 0 && m_cnt < 65535) begin
        m_cnt++;
      end
      m_prev = fclk;
    end
    cyc++;
    @(negedge Clk);
  endtask

  initial begin
    logic [NREQ*AW-1:0] a;
    logic [NREQ-1:0]    r;
    bit                 fc;
    int                 g;
    Reset = 1'b1; req = '0; req_addr = '0; frame_clk = 1'b0;
    m_ptr = 0; m_cnt = 0; m_fg = 0; m_prev = 0; m_rdata = '0; cyc = 0;
    @(negedge Clk);

    // Reset state.
    step(1, '0, '0, 0);
    check("rst_ptr", seen_ptr, 0);
    step(0, '0, '0, 0);
    check("rst_rdata", seen_rdata, 0);
    check("rst_fg", seen_fg, 0);

    // All four requesting: strict rotation, returns ROM_LAT cycles later.
    for (int k = 0; k < 8 + ROM_LAT; k++) begin
      step(0, (k < 8) ? 4'b1111 : 4'b0000, rand_addrs(), 0);
      if (k < 8) check("rr_order", seen_gnt, 4'b0001 << (k % 4));
      if (k >= ROM_LAT) check("rv_order", seen_rvalid, 4'b0001 << ((k - ROM_LAT) % 4));
    end

    // Lone requester gets every cycle; words stream back in order.
    for (int k = 0; k < 5 + ROM_LAT; k++) begin
      a = '0;
      a[2*AW +: AW] = 16'h0010 + 16'(k);
      step(0, (k < 5) ? 4'b0100 : 4'b0000, a, 0);
      if (k < 5) check("solo_gnt", seen_gnt, 4'b0100);
      if (k >= ROM_LAT) begin
        check("solo_rv", seen_rvalid, 4'b0100);
        check("solo_data", seen_rdata, rom_word(16'h0010 + 16'(k - ROM_LAT)));
      end
    end

    // Frame edge forces the search to start at requester 0.
    step(0, 4'b0100, rand_addrs(), 0);
    check("ptr3", seen_ptr, 3);
    step(0, 4'b1001, rand_addrs(), 1);
    check("edge_gnt", seen_gnt, 4'b0001);
    step(0, 4'b1001, rand_addrs(), 1);
    check("after_edge_gnt", seen_gnt, 4'b1000);
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);

    // Exactly 37 grants in one frame.
    step(0, '0, '0, 1);
    g = 0;
    while (g < 37) begin
      r = 4'($urandom_range(0, 15));
      if (r != '0) g++;
      step(0, r, rand_addrs(), 1);
    end
    step(0, '0, '0, 0);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    check("fg37", seen_fg, 37);
    check("cnt_restart0", seen_cnt, 0);
    step(0, '0, '0, 0);
    step(0, 4'b0001, rand_addrs(), 1);
    step(0, '0, '0, 1);
    check("cnt_restart1", seen_cnt, 1);

    // Randomized traffic with frame strobes and occasional resets.
    fc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) fc = ~fc;
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), r, rand_addrs(), fc);
    end

    // Grant to requester 1 then reset: its read must never return.
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    step(0, 4'b0010, rand_addrs(), 0);
    step(1, '0, '0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, '0, '0, 0);
      check("rst_no_rv", seen_rvalid, 0);
    end
    check("rst_ptr0", seen_ptr, 0);

    // Counter saturation.
    force dut.cnt = 16'hFFFE;
    #1;
    release dut.cnt;
    m_cnt = 65534;
    for (int k = 0; k < 3; k++) step(0, 4'b0001, rand_addrs(), 0);
    step(0, '0, '0, 0);
    check("cnt_sat", seen_cnt, 16'hFFFF);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    check("fg_sat", seen_fg, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
